// File: rtl/bcd_timer_pkg.sv
// Shared types, digit limits, bus field offsets and BCD helpers for the
// three-digit up timer.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int UNI_MAX = 9;
    localparam int DEZ_MAX = 9;
    localparam int CEN_MAX = 3;

    localparam int UNI_LSB = 0;
    localparam int DEZ_LSB = 4;
    localparam int CEN_LSB = 8;
    localparam int UNI_W   = 4;
    localparam int DEZ_W   = 4;
    localparam int CEN_W   = 2;
    localparam int BUS_W   = 10;

    function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] lim);
        logic [3:0] r;
        if (d > lim) begin
            r = lim;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Out-of-range digits clamp to the digit's maximum rather than being rejected
    function automatic logic [BUS_W-1:0] sat_preset(input logic [BUS_W-1:0] p);
        logic [UNI_W-1:0] u;
        logic [DEZ_W-1:0] d;
        logic [CEN_W-1:0] c;
        u = sat_digit(p[UNI_LSB +: UNI_W], 4'(UNI_MAX));
        d = sat_digit(p[DEZ_LSB +: DEZ_W], 4'(DEZ_MAX));
        c = (p[CEN_LSB +: CEN_W] > 2'(CEN_MAX)) ? 2'(CEN_MAX) : p[CEN_LSB +: CEN_W];
        return {c, d, u};
    endfunction

    function automatic logic [BUS_W-1:0] bcd_inc(input logic [BUS_W-1:0] v);
        logic [UNI_W-1:0] u;
        logic [DEZ_W-1:0] d;
        logic [CEN_W-1:0] c;
        u = v[UNI_LSB +: UNI_W];
        d = v[DEZ_LSB +: DEZ_W];
        c = v[CEN_LSB +: CEN_W];
        if (u == 4'(UNI_MAX)) begin
            u = 4'd0;
            if (d == 4'(DEZ_MAX)) begin
                d = 4'd0;
                c = (c == 2'(CEN_MAX)) ? 2'd0 : c + 2'd1;
            end else begin
                d = d + 4'd1;
            end
        end else begin
            u = u + 4'd1;
        end
        return {c, d, u};
    endfunction

endpackage

// File: rtl/bcd_up_timer_if.sv
// Control/status bundle between the button front end and the BCD up timer.
interface bcd_up_timer_if;

    logic       botao;
    logic [9:0] preset;
    logic       start;
    logic       pause;
    logic       clear;
    logic [9:0] Q;
    logic       running;
    logic       done;
    logic       fim;

    modport master (
        output botao, preset, start, pause, clear,
        input  Q, running, done, fim
    );

    modport slave (
        input  botao, preset, start, pause, clear,
        output Q, running, done, fim
    );

endinterface

// File: rtl/bcd_digit_up.sv
// Single mod-(MAX+1) BCD up digit; carry is high when an increment wraps it.
module bcd_digit_up #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] TOP = W'(MAX);

    assign carry = inc && (q == TOP);

    // Digit register: clear has priority over increment
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (inc) begin
            q <= (q == TOP) ? {W{1'b0}} : q + W'(1);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/bcd_up_timer.sv
// Three-digit BCD up timer (000..399) with prescaler, pause/resume and target stop.
// Optional build macro: BCD_UP_TIMER_AUTORESTART_EN (wrap to 000 after the target).
module bcd_up_timer
    import bcd_timer_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    bcd_up_timer_if.slave bus
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [BUS_W-1:0]   target_r;
    logic [PW-1:0]      presc_r;
    logic [PW-1:0]      presc_nxt_s;
    logic               running_r;
    logic               done_r;
    logic               fim_r;
    logic               fim_nxt_s;
    logic               load_s;
    logic               tick_s;
    logic               count_inc_s;
    logic               count_clr_s;
    logic [BUS_W-1:0]   count_s;
    logic [BUS_W-1:0]   count_next_s;
    logic [UNI_W-1:0]   uni_q_s;
    logic [DEZ_W-1:0]   dez_q_s;
    logic [CEN_W-1:0]   cen_q_s;
    logic               uni_carry_s;
    logic               dez_carry_s;
    logic               cen_carry_unused_s;

    bcd_digit_up #(.MAX(UNI_MAX), .W(UNI_W)) u_uni (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (count_inc_s),
        .clr     (count_clr_s),
        .q       (uni_q_s),
        .carry   (uni_carry_s)
    );

    bcd_digit_up #(.MAX(DEZ_MAX), .W(DEZ_W)) u_dez (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (uni_carry_s),
        .clr     (count_clr_s),
        .q       (dez_q_s),
        .carry   (dez_carry_s)
    );

    bcd_digit_up #(.MAX(CEN_MAX), .W(CEN_W)) u_cen (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (dez_carry_s),
        .clr     (count_clr_s),
        .q       (cen_q_s),
        .carry   (cen_carry_unused_s)
    );

    assign count_s      = {cen_q_s, dez_q_s, uni_q_s};
    assign count_next_s = bcd_inc(count_s);
    assign tick_s       = (state_r == RUN) && (presc_r == PRESC_LAST);

    assign bus.Q       = count_s;
    assign bus.running = running_r;
    assign bus.done    = done_r;
    assign bus.fim     = fim_r;

    // Next-state, prescaler and digit-chain control; clear > pause > start
    always_comb begin
        state_nxt_s = state_r;
        presc_nxt_s = presc_r;
        count_inc_s = 1'b0;
        count_clr_s = 1'b0;
        fim_nxt_s   = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                load_s = bus.botao;
                if (bus.clear) begin
                    state_nxt_s = IDLE;
                    count_clr_s = 1'b1;
                    presc_nxt_s = {PW{1'b0}};
                end else if (bus.start) begin
                    count_clr_s = 1'b1;
                    presc_nxt_s = {PW{1'b0}};
`ifdef BCD_UP_TIMER_AUTORESTART_EN
                    state_nxt_s = RUN;
`else
                    if (target_r == 10'd0) begin
                        state_nxt_s = DONE;
                        fim_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
`endif
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RUN: begin
                if (bus.clear) begin
                    state_nxt_s = IDLE;
                    count_clr_s = 1'b1;
                    presc_nxt_s = {PW{1'b0}};
                end else if (bus.pause) begin
                    state_nxt_s = HOLD;
                end else if (tick_s) begin
                    presc_nxt_s = {PW{1'b0}};
`ifdef BCD_UP_TIMER_AUTORESTART_EN
                    // Target is shown for one full tick period, then the count wraps to 000
                    if (count_s == target_r) begin
                        count_clr_s = 1'b1;
                        fim_nxt_s   = (target_r == 10'd0);
                    end else begin
                        count_inc_s = 1'b1;
                        fim_nxt_s   = (count_next_s == target_r);
                    end
`else
                    count_inc_s = 1'b1;
                    if (count_next_s == target_r) begin
                        state_nxt_s = DONE;
                        fim_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
`endif
                end else begin
                    presc_nxt_s = presc_r + PW'(1);
                end
            end
            HOLD: begin
                if (bus.clear) begin
                    state_nxt_s = IDLE;
                    count_clr_s = 1'b1;
                    presc_nxt_s = {PW{1'b0}};
                end else if (bus.start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                count_clr_s = 1'b1;
                presc_nxt_s = {PW{1'b0}};
            end
        endcase
    end

    // State, prescaler, target and registered status outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            presc_r   <= {PW{1'b0}};
            target_r  <= 10'd0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            fim_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            presc_r   <= presc_nxt_s;
            target_r  <= load_s ? sat_preset(bus.preset) : target_r;
            running_r <= (state_nxt_s == RUN);
            done_r    <= (state_nxt_s == DONE);
            fim_r     <= fim_nxt_s;
        end
    end

endmodule

// File: tb/tb_bcd_up_timer.sv
// Self-checking bench for bcd_up_timer: vector table with scoreboard on a DIV=1
// instance, hand-written prescaler/hold sequences on a DIV=3 instance.
module tb_bcd_up_timer;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    bcd_up_timer_if bus1 ();
    bcd_up_timer_if bus3 ();

    bcd_up_timer #(.DIV(1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));
    bcd_up_timer #(.DIV(3)) dut3 (.clock(clock), .reset_n(reset_n), .bus(bus3));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       botao;
        logic [9:0] preset;
        logic       start;
        logic       pause;
        logic       clear;
        logic [9:0] q;
        logic       running;
        logic       done;
        logic       fim;
    } vec_t;

    typedef struct {
        logic [9:0] q;
        logic       running;
        logic       done;
        logic       fim;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] to_bcd(input int k);
        logic [9:0] r;
        r[9:8] = 2'(k / 100);
        r[7:4] = 4'((k / 10) % 10);
        r[3:0] = 4'(k % 10);
        return r;
    endfunction

    function automatic void add(input logic b, input logic [9:0] p, input logic s,
                                input logic pa, input logic c, input logic [9:0] q,
                                input logic r, input logic d, input logic f);
        vec_t v;
        v.botao = b; v.preset = p; v.start = s; v.pause = pa; v.clear = c;
        v.q = q; v.running = r; v.done = d; v.fim = f;
        vecs.push_back(v);
    endfunction

    function automatic void build_table();
`ifdef BCD_UP_TIMER_AUTORESTART_EN
        add(1'b1, 10'h003, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h001, 1'b1, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h002, 1'b1, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h003, 1'b1, 1'b0, 1'b1);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h001, 1'b1, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h002, 1'b1, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h003, 1'b1, 1'b0, 1'b1);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0);
`else
        // load target 012, count to it
        add(1'b1, 10'h012, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++)
            add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, to_bcd(k), k < 12, k == 12, k == 12);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h012, 1'b0, 1'b1, 1'b0);
        // load 3FF in DONE (stays DONE), restart; botao at count 3 must be ignored
        add(1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, 10'h012, 1'b0, 1'b1, 1'b0);
        add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 399; k++)
            add(k == 3, (k == 3) ? 10'h005 : 10'h000, 1'b0, 1'b0, 1'b0,
                to_bcd(k), k < 399, k == 399, k == 399);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h399, 1'b0, 1'b1, 1'b0);
        add(1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0);
        // target 000: start goes straight to DONE with one fim
        add(1'b1, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
        // pause+start together -> HOLD; resume; clear+start -> IDLE
        add(1'b1, 10'h050, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
        add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++)
            add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, to_bcd(k), 1'b1, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h003, 1'b0, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h003, 1'b0, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h003, 1'b1, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h004, 1'b1, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
`endif
    endfunction

    initial begin
        exp_t e;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bus1.botao = 1'b0; bus1.preset = 10'h000; bus1.start = 1'b0; bus1.pause = 1'b0; bus1.clear = 1'b0;
        bus3.botao = 1'b0; bus3.preset = 10'h000; bus3.start = 1'b0; bus3.pause = 1'b0; bus3.clear = 1'b0;
        #12;
        check("reset_q", 32'(bus1.Q), 32'h0);
        check("reset_running", 32'(bus1.running), 32'h0);
        check("reset_done", 32'(bus1.done), 32'h0);
        check("reset_fim", 32'(bus1.fim), 32'h0);
        reset_n = 1'b1;

        build_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            bus1.botao  = vecs[i].botao;
            bus1.preset = vecs[i].preset;
            bus1.start  = vecs[i].start;
            bus1.pause  = vecs[i].pause;
            bus1.clear  = vecs[i].clear;
            e.q = vecs[i].q; e.running = vecs[i].running; e.done = vecs[i].done; e.fim = vecs[i].fim;
            sb.push_back(e);
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                check($sformatf("vec%0d_sb_empty", i), 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                check($sformatf("vec%0d_q", i), 32'(bus1.Q), 32'(e.q));
                check($sformatf("vec%0d_running", i), 32'(bus1.running), 32'(e.running));
                check($sformatf("vec%0d_done", i), 32'(bus1.done), 32'(e.done));
                check($sformatf("vec%0d_fim", i), 32'(bus1.fim), 32'(e.fim));
            end
        end
        @(negedge clock);
        bus1.botao = 1'b0; bus1.start = 1'b0; bus1.pause = 1'b0; bus1.clear = 1'b0;

`ifndef BCD_UP_TIMER_AUTORESTART_EN
        // DIV=3, target 100: carry chain and prescaled steps
        @(negedge clock); bus3.botao = 1'b1; bus3.preset = 10'h100;
        @(negedge clock); bus3.botao = 1'b0; bus3.start = 1'b1;
        @(negedge clock); bus3.start = 1'b0;
        check("div3_running", 32'(bus3.running), 32'h1);
        for (int ed = 1; ed <= 301; ed++) begin
            @(posedge clock);
            #1;
            if (ed == 2 || ed == 3 || ed == 297 || ed == 299 || ed == 300 || ed == 301)
                check($sformatf("div3_q_e%0d", ed), 32'(bus3.Q), 32'(to_bcd(ed / 3)));
            if (ed == 300) begin
                check("div3_done_e300", 32'(bus3.done), 32'h1);
                check("div3_fim_e300", 32'(bus3.fim), 32'h1);
            end
            if (ed == 301)
                check("div3_fim_e301", 32'(bus3.fim), 32'h0);
        end

        // restart from DONE, pause mid-phase at 005, hold 20 cycles, resume
        @(negedge clock); bus3.start = 1'b1;
        @(negedge clock); bus3.start = 1'b0;
        for (int ed = 1; ed <= 16; ed++) begin
            @(posedge clock);
            #1;
            if (ed == 15)
                check("hold_q_e15", 32'(bus3.Q), 32'h005);
        end
        @(negedge clock); bus3.pause = 1'b1;
        @(negedge clock); bus3.pause = 1'b0;
        check("hold_running", 32'(bus3.running), 32'h0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            check($sformatf("hold_q_c%0d", c), 32'(bus3.Q), 32'h005);
        end
        @(negedge clock); bus3.start = 1'b1;
        @(negedge clock); bus3.start = 1'b0;
        check("resume_running", 32'(bus3.running), 32'h1);
        @(posedge clock); #1;
        check("resume_q_r1", 32'(bus3.Q), 32'h005);
        @(posedge clock); #1;
        check("resume_q_r2", 32'(bus3.Q), 32'h006);
        @(negedge clock); bus3.clear = 1'b1;
        @(negedge clock); bus3.clear = 1'b0;
        check("div3_clear_q", 32'(bus3.Q), 32'h000);
`endif

        // asynchronous reset in the middle of a count
        @(negedge clock); bus1.botao = 1'b1; bus1.preset = 10'h050;
        @(negedge clock); bus1.botao = 1'b0; bus1.start = 1'b1;
        @(negedge clock); bus1.start = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        check("prereset_q", 32'(bus1.Q), 32'h005);
        reset_n = 1'b0;
        #1;
        check("async_reset_q", 32'(bus1.Q), 32'h0);
        check("async_reset_running", 32'(bus1.running), 32'h0);
        check("async_reset_done", 32'(bus1.done), 32'h0);
        check("async_reset_fim", 32'(bus1.fim), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
